// File: rtl/store_commit_buffer.sv
// Store commit buffer: holds executed stores as speculative entries, marks them
// committed in order and drains committed entries to the data cache.
module store_commit_buffer #(
  parameter int DEPTH = 8,
  parameter int PLEN  = 56,
  parameter int XLEN  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              store_valid_i,
  output logic              store_ready_o,
  input  logic [PLEN-1:0]   store_paddr_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [XLEN/8-1:0] store_be_i,
  input  logic              commit_i,
  output logic              commit_ready_o,
  input  logic              flush_i,
  output logic              no_st_pending_o,
  input  logic [11:0]       page_offset_i,
  output logic              page_offset_match_o,
  output logic              req_o,
  output logic [PLEN-1:0]   addr_o,
  output logic [XLEN-1:0]   data_o,
  output logic [XLEN/8-1:0] be_o,
  input  logic              gnt_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [PLEN-1:0]   paddr_mem [DEPTH];
  logic [XLEN-1:0]   data_mem  [DEPTH];
  logic [XLEN/8-1:0] be_mem    [DEPTH];

  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] cm_ptr_reg, cm_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] commit_cnt_reg, commit_cnt_next;
  logic [CW-1:0] spec_cnt_reg, spec_cnt_next;

  logic [CW-1:0] occupied;
  logic          do_push;
  logic          do_commit;
  logic          do_drain;

  assign occupied        = commit_cnt_reg + spec_cnt_reg;
  assign store_ready_o   = occupied < CW'(DEPTH);
  assign commit_ready_o  = spec_cnt_reg != '0;
  assign no_st_pending_o = commit_cnt_reg == '0;
  assign req_o           = commit_cnt_reg != '0;
  assign addr_o          = paddr_mem[rd_ptr_reg];
  assign data_o          = data_mem[rd_ptr_reg];
  assign be_o            = be_mem[rd_ptr_reg];

  assign do_push   = store_valid_i & store_ready_o;
  assign do_commit = commit_i & commit_ready_o;
  assign do_drain  = req_o & gnt_i;

  // A flush rewinds the write side to the post-commit boundary, so a push in
  // the same cycle never becomes visible.
  always_comb begin
    rd_ptr_next     = rd_ptr_reg + PW'(do_drain);
    cm_ptr_next     = cm_ptr_reg + PW'(do_commit);
    commit_cnt_next = commit_cnt_reg + CW'(do_commit) - CW'(do_drain);
    wr_ptr_next     = wr_ptr_reg + PW'(do_push);
    spec_cnt_next   = spec_cnt_reg + CW'(do_push) - CW'(do_commit);
    if (flush_i) begin
      wr_ptr_next   = cm_ptr_next;
      spec_cnt_next = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_reg     <= '0;
      cm_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      commit_cnt_reg <= '0;
      spec_cnt_reg   <= '0;
    end else begin
      rd_ptr_reg     <= rd_ptr_next;
      cm_ptr_reg     <= cm_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      commit_cnt_reg <= commit_cnt_next;
      spec_cnt_reg   <= spec_cnt_next;
    end
  end

  // Entry storage carries no reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !rst_i) begin
      paddr_mem[wr_ptr_reg] <= store_paddr_i;
      data_mem[wr_ptr_reg]  <= store_data_i;
      be_mem[wr_ptr_reg]    <= store_be_i;
    end
  end

  logic [DEPTH-1:0] slot_match;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PW-1:0] age;
      logic          live;
      // Distance from the oldest entry decides whether this slot is occupied.
      assign age  = PW'(gi) - rd_ptr_reg;
      assign live = {1'b0, age} < occupied;
      assign slot_match[gi] = live && (paddr_mem[gi][11:3] == page_offset_i[11:3]);
    end
  endgenerate

  assign page_offset_match_o = |slot_match;

  logic unused_offset_bits;
  assign unused_offset_bits = ^page_offset_i[2:0];

endmodule

// File: tb/tb_store_commit_buffer.sv
// Randomized self-checking bench for store_commit_buffer against a queue-based
// reference model of committed and speculative stores.
module tb_store_commit_buffer;

  localparam int DEPTH = 8;
  localparam int PLEN  = 56;
  localparam int XLEN  = 64;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              store_valid_i = 1'b0;
  logic              store_ready_o;
  logic [PLEN-1:0]   store_paddr_i = '0;
  logic [XLEN-1:0]   store_data_i = '0;
  logic [XLEN/8-1:0] store_be_i = '0;
  logic              commit_i = 1'b0;
  logic              commit_ready_o;
  logic              flush_i = 1'b0;
  logic              no_st_pending_o;
  logic [11:0]       page_offset_i = '0;
  logic              page_offset_match_o;
  logic              req_o;
  logic [PLEN-1:0]   addr_o;
  logic [XLEN-1:0]   data_o;
  logic [XLEN/8-1:0] be_o;
  logic              gnt_i = 1'b0;

  store_commit_buffer #(.DEPTH(DEPTH), .PLEN(PLEN), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .store_valid_i(store_valid_i), .store_ready_o(store_ready_o),
    .store_paddr_i(store_paddr_i), .store_data_i(store_data_i), .store_be_i(store_be_i),
    .commit_i(commit_i), .commit_ready_o(commit_ready_o),
    .flush_i(flush_i), .no_st_pending_o(no_st_pending_o),
    .page_offset_i(page_offset_i), .page_offset_match_o(page_offset_match_o),
    .req_o(req_o), .addr_o(addr_o), .data_o(data_o), .be_o(be_o), .gnt_i(gnt_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [PLEN-1:0]   pa;
    logic [XLEN-1:0]   d;
    logic [XLEN/8-1:0] be;
  } ent_t;

  ent_t cq[$];
  ent_t sq[$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_match(input logic [11:0] po);
    bit m = 0;
    foreach (cq[i]) if (cq[i].pa[11:3] == po[11:3]) m = 1;
    foreach (sq[i]) if (sq[i].pa[11:3] == po[11:3]) m = 1;
    return m;
  endfunction

  // Drive one cycle of inputs, compare outputs with the model, then advance the model.
  task automatic cycle(input logic rst, input logic valid, input logic [PLEN-1:0] pa,
                       input logic [XLEN-1:0] d, input logic [XLEN/8-1:0] be,
                       input logic cm, input logic fl, input logic g, input logic [11:0] po);
    bit ready, do_commit, do_drain, do_push;
    ent_t e;
    @(negedge clk_i);
    rst_i = rst; store_valid_i = valid; store_paddr_i = pa; store_data_i = d;
    store_be_i = be; commit_i = cm; flush_i = fl; gnt_i = g; page_offset_i = po;
    #1;
    ready     = (cq.size() + sq.size()) < DEPTH;
    do_commit = cm && (sq.size() > 0);
    do_drain  = g && (cq.size() > 0);
    do_push   = valid && ready;
    check("store_ready", 64'(store_ready_o), 64'(ready));
    check("commit_ready", 64'(commit_ready_o), 64'(sq.size() > 0));
    check("no_st_pending", 64'(no_st_pending_o), 64'(cq.size() == 0));
    check("req", 64'(req_o), 64'(cq.size() > 0));
    check("page_match", 64'(page_offset_match_o), 64'(model_match(po)));
    if (cq.size() > 0) begin
      check("addr", 64'(addr_o), 64'(cq[0].pa));
      check("data", data_o, cq[0].d);
      check("be", 64'(be_o), 64'(cq[0].be));
    end
    if (rst) begin
      cq.delete();
      sq.delete();
    end else begin
      if (do_drain) begin
        $display("[TB] drain addr=0x%0h data=0x%0h be=0x%0h", cq[0].pa, cq[0].d, cq[0].be);
        void'(cq.pop_front());
      end
      if (do_commit) begin
        e = sq.pop_front();
        cq.push_back(e);
      end
      if (fl) sq.delete();
      else if (do_push) begin
        e.pa = pa; e.d = d; e.be = be;
        sq.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic cm, input logic g);
    cycle(1'b0, 1'b0, '0, '0, '0, cm, 1'b0, g, 12'h000);
  endtask

  task automatic push(input logic [PLEN-1:0] pa);
    cycle(1'b0, 1'b1, pa, {$urandom, $urandom}, 8'($urandom), 1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic after_edge();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    do_reset();
    after_edge();
    check("rst_store_ready", 64'(store_ready_o), 64'd1);
    check("rst_req", 64'(req_o), 64'd0);
    check("rst_no_st_pending", 64'(no_st_pending_o), 64'd1);

    push(56'h1000); push(56'h1008); push(56'h1010);
    idle(1'b1, 1'b0);
    after_edge();
    check("tp1_req_after_commit", 64'(req_o), 64'd1);
    check("tp1_addr0", 64'(addr_o), 64'h1000);
    idle(1'b1, 1'b0);
    after_edge();
    check("tp1_no_st_pending", 64'(no_st_pending_o), 64'd0);
    check("tp1_commit_ready", 64'(commit_ready_o), 64'd1);
    idle(1'b0, 1'b1);
    after_edge();
    check("tp2_addr1", 64'(addr_o), 64'h1008);
    idle(1'b0, 1'b1);
    after_edge();
    check("tp2_req_done", 64'(req_o), 64'd0);
    check("tp2_commit_ready", 64'(commit_ready_o), 64'd1);

    // Fill, overflow attempt, commit all, free one slot, wrap the write pointer.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(56'h3000 + 56'(i * 8));
    after_edge();
    check("full_store_ready", 64'(store_ready_o), 64'd0);
    push(56'h3FF8);
    for (int i = 0; i < DEPTH; i++) idle(1'b1, 1'b0);
    idle(1'b0, 1'b1);
    after_edge();
    check("full_freed_ready", 64'(store_ready_o), 64'd1);
    push(56'h4000);
    for (int i = 0; i < DEPTH; i++) idle(1'b1, 1'b1);

    // Commit, flush and push on the same edge.
    do_reset();
    for (int i = 0; i < 5; i++) push(56'h5000 + 56'(i * 8));
    idle(1'b1, 1'b0); idle(1'b1, 1'b0);
    cycle(1'b0, 1'b1, 56'h5FF0, 64'h1, 8'hFF, 1'b1, 1'b1, 1'b0, 12'h000);
    after_edge();
    check("flush_commit_ready", 64'(commit_ready_o), 64'd0);
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b1);

    // Page-offset hazard against a single entry.
    do_reset();
    push(56'h2ABC);
    after_edge();
    page_offset_i = 12'hAB8; #1;
    check("po_match_hit", 64'(page_offset_match_o), 64'd1);
    page_offset_i = 12'hAC0; #1;
    check("po_match_miss", 64'(page_offset_match_o), 64'd0);
    idle(1'b1, 1'b0); idle(1'b0, 1'b1);
    after_edge();
    page_offset_i = 12'hAB8; #1;
    check("po_match_drained", 64'(page_offset_match_o), 64'd0);

    // Reset while a request is outstanding.
    do_reset();
    for (int i = 0; i < 4; i++) push(56'h6000 + 56'(i * 8));
    idle(1'b1, 1'b0); idle(1'b0, 1'b0);
    do_reset();
    after_edge();
    check("mid_rst_req", 64'(req_o), 64'd0);
    check("mid_rst_commit_ready", 64'(commit_ready_o), 64'd0);
    check("mid_rst_store_ready", 64'(store_ready_o), 64'd1);

    // Randomized traffic with a narrow page-offset space to provoke matches.
    for (int n = 0; n < 3000; n++) begin
      logic [PLEN-1:0] pa;
      pa = {44'({$urandom, $urandom}), 12'($urandom_range(0, 15) * 8)};
      cycle(1'($urandom_range(0, 99) < 2),
            1'($urandom_range(0, 99) < 65), pa, {$urandom, $urandom}, 8'($urandom),
            1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 99) < 5),
            1'($urandom_range(0, 99) < 35),
            12'($urandom_range(0, 15) * 8 + $urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
